// File: rtl/register_file_sb_if.sv
// Register file port bundle: two read ports, one write port, one reserve port, busy count.
interface register_file_sb_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic                  Busy1;
    logic                  Busy2;
    logic                  Write;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  Reserve;
    logic [ADDR_WIDTH-1:0] ReserveRegister;
    logic [ADDR_WIDTH:0]   BusyCount;

    modport master (
        output ReadRegister1, ReadRegister2, Write, WriteRegister, WriteData,
               Reserve, ReserveRegister,
        input  ReadData1, ReadData2, Busy1, Busy2, BusyCount
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, Write, WriteRegister, WriteData,
               Reserve, ReserveRegister,
        output ReadData1, ReadData2, Busy1, Busy2, BusyCount
    );
endinterface

// File: rtl/register_file_sb.sv
// General-purpose register file with combinational reads, optional write bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module register_file_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic               clk,
    input  logic               reset,
    register_file_sb_if.slave  rf
);
    localparam int unsigned NUM_REGS  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic        ZERO_EN   = (ZERO_REG != 0);
    localparam logic        BYP_EN    = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [CNT_WIDTH-1:0]  busy_count;
    logic                  write_ok;
    logic                  reserve_ok;
    logic                  cnt_inc;
    logic                  cnt_dec;

    // Requests to the hardwired zero register, or during reset, are dropped here.
    always_comb begin
        write_ok   = rf.Write && !reset &&
                     !(ZERO_EN && (rf.WriteRegister == '0));
        reserve_ok = rf.Reserve && !reset &&
                     !(ZERO_EN && (rf.ReserveRegister == '0));
    end

    // Reserve is applied after the write so a same-register pair leaves the entry busy.
    always_comb begin
        busy_next = busy;
        if (write_ok) busy_next[rf.WriteRegister] = 1'b0;
        if (reserve_ok) busy_next[rf.ReserveRegister] = 1'b1;
    end

    always_comb begin
        cnt_inc = reserve_ok && !busy[rf.ReserveRegister];
        cnt_dec = write_ok && busy[rf.WriteRegister] &&
                  !(reserve_ok && (rf.ReserveRegister == rf.WriteRegister));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[ADDR_WIDTH'(i)] <= '0;
            end
        end else if (write_ok) begin
            regs[rf.WriteRegister] <= rf.WriteData;
        end
    end

    // Count tracks the popcount of busy incrementally; net step is -1, 0 or +1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy <= busy_next;
            if (cnt_inc && !cnt_dec) begin
                busy_count <= busy_count + CNT_WIDTH'(1);
            end else if (cnt_dec && !cnt_inc) begin
                busy_count <= busy_count - CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        rf.ReadData1 = regs[rf.ReadRegister1];
        rf.Busy1     = busy[rf.ReadRegister1];
        if (BYP_EN && write_ok && (rf.WriteRegister == rf.ReadRegister1)) begin
            rf.ReadData1 = rf.WriteData;
            rf.Busy1     = 1'b0;
        end
        if ((ZERO_EN && (rf.ReadRegister1 == '0)) || reset) begin
            rf.ReadData1 = '0;
            rf.Busy1     = 1'b0;
        end
    end

    always_comb begin
        rf.ReadData2 = regs[rf.ReadRegister2];
        rf.Busy2     = busy[rf.ReadRegister2];
        if (BYP_EN && write_ok && (rf.WriteRegister == rf.ReadRegister2)) begin
            rf.ReadData2 = rf.WriteData;
            rf.Busy2     = 1'b0;
        end
        if ((ZERO_EN && (rf.ReadRegister2 == '0)) || reset) begin
            rf.ReadData2 = '0;
            rf.Busy2     = 1'b0;
        end
    end

    always_comb rf.BusyCount = busy_count;
endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: default, no-bypass and no-zero-register instances
// share one stimulus stream; vector expectations go through a scoreboard queue.
module tb_register_file_sb;
    logic clk = 1'b0;
    logic reset;
    logic        write;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        reserve;
    logic [4:0]  rsreg;
    logic [4:0]  r1;
    logic [4:0]  r2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    register_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifa ();
    register_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifb ();
    register_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifc ();

    assign ifa.Write = write;   assign ifb.Write = write;   assign ifc.Write = write;
    assign ifa.WriteRegister = wreg;   assign ifb.WriteRegister = wreg;   assign ifc.WriteRegister = wreg;
    assign ifa.WriteData = wdata;   assign ifb.WriteData = wdata;   assign ifc.WriteData = wdata;
    assign ifa.Reserve = reserve;   assign ifb.Reserve = reserve;   assign ifc.Reserve = reserve;
    assign ifa.ReserveRegister = rsreg;   assign ifb.ReserveRegister = rsreg;   assign ifc.ReserveRegister = rsreg;
    assign ifa.ReadRegister1 = r1;   assign ifb.ReadRegister1 = r1;   assign ifc.ReadRegister1 = r1;
    assign ifa.ReadRegister2 = r2;   assign ifb.ReadRegister2 = r2;   assign ifc.ReadRegister2 = r2;

    register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .reset(reset), .rf(ifa.slave));
    register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0))
        dut_b (.clk(clk), .reset(reset), .rf(ifb.slave));
    register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(1))
        dut_c (.clk(clk), .reset(reset), .rf(ifc.slave));

    typedef struct {
        logic        wr;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        rs;
        logic [4:0]  rsreg;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
        logic [5:0]  cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
        logic [5:0]  cnt;
    } exp_t;

    vec_t vecs [20];
    exp_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int unsigned wr, input int unsigned wr_reg,
                                input int unsigned wr_data, input int unsigned rs,
                                input int unsigned rs_reg, input int unsigned ra,
                                input int unsigned rb, input int unsigned d1,
                                input int unsigned b1, input int unsigned d2,
                                input int unsigned b2, input int unsigned cnt);
        vec_t v;
        v.wr = 1'(wr);       v.wreg = 5'(wr_reg);  v.wdata = 32'(wr_data);
        v.rs = 1'(rs);       v.rsreg = 5'(rs_reg); v.r1 = 5'(ra);  v.r2 = 5'(rb);
        v.d1 = 32'(d1);      v.b1 = 1'(b1);        v.d2 = 32'(d2); v.b2 = 1'(b2);
        v.cnt = 6'(cnt);
        return v;
    endfunction

    task automatic drive(input logic w, input logic [4:0] wr_reg, input logic [31:0] wr_data,
                         input logic rs, input logic [4:0] rs_reg,
                         input logic [4:0] ra, input logic [4:0] rb);
        write = w; wreg = wr_reg; wdata = wr_data;
        reserve = rs; rsreg = rs_reg; r1 = ra; r2 = rb;
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra, rb);
    endtask

    // Scoreboard consumer: compares default-instance outputs mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("vec%0d ReadData1", e.idx), ifa.ReadData1, e.d1);
            chk($sformatf("vec%0d Busy1", e.idx), 32'(ifa.Busy1), 32'(e.b1));
            chk($sformatf("vec%0d ReadData2", e.idx), ifa.ReadData2, e.d2);
            chk($sformatf("vec%0d Busy2", e.idx), 32'(ifa.Busy2), 32'(e.b2));
            chk($sformatf("vec%0d BusyCount", e.idx), 32'(ifa.BusyCount), 32'(e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //             wr wreg wdata        rs rsreg r1 r2  d1           b1 d2           b2 cnt
        vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  5, 5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0);
        vecs[1]  = mk(0, 0,  0,            0, 0,  5, 0,  32'hDEADBEEF, 0, 0,            0, 0);
        vecs[2]  = mk(1, 0,  32'h12345678, 1, 0,  0, 5,  0,            0, 32'hDEADBEEF, 0, 0);
        vecs[3]  = mk(0, 0,  0,            0, 0,  0, 0,  0,            0, 0,            0, 0);
        vecs[4]  = mk(0, 0,  0,            1, 7,  7, 9,  0,            0, 0,            0, 0);
        vecs[5]  = mk(0, 0,  0,            1, 9,  7, 9,  0,            1, 0,            0, 1);
        vecs[6]  = mk(1, 7,  32'hA5A5A5A5, 0, 0,  7, 9,  32'hA5A5A5A5, 0, 0,            1, 2);
        vecs[7]  = mk(0, 0,  0,            0, 0,  7, 9,  32'hA5A5A5A5, 0, 0,            1, 1);
        vecs[8]  = mk(0, 0,  0,            1, 3,  3, 3,  0,            0, 0,            0, 1);
        vecs[9]  = mk(1, 3,  1,            1, 3,  3, 9,  1,            0, 0,            1, 2);
        vecs[10] = mk(0, 0,  0,            0, 0,  3, 3,  1,            1, 1,            1, 2);
        vecs[11] = mk(1, 9,  32'h55,       1, 12, 9, 12, 32'h55,       0, 0,            0, 2);
        vecs[12] = mk(0, 0,  0,            0, 0,  9, 12, 32'h55,       0, 0,            1, 2);
        vecs[13] = mk(1, 20, 32'hCAFEF00D, 1, 3,  20, 3, 32'hCAFEF00D, 0, 1,            1, 2);
        vecs[14] = mk(0, 0,  0,            0, 0,  20, 3, 32'hCAFEF00D, 0, 1,            1, 2);
        vecs[15] = mk(1, 3,  2,            1, 20, 3, 20, 2,            0, 32'hCAFEF00D, 0, 2);
        vecs[16] = mk(0, 0,  0,            0, 0,  3, 20, 2,            0, 32'hCAFEF00D, 1, 2);
        vecs[17] = mk(1, 12, 0,            0, 0,  12, 12, 0,           0, 0,            0, 2);
        vecs[18] = mk(1, 20, 7,            0, 0,  20, 31, 7,           0, 0,            0, 1);
        vecs[19] = mk(0, 0,  0,            0, 0,  20, 12, 7,           0, 0,            0, 0);

        reset = 1'b1;
        idle(5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset: every register reads zero and nothing is busy.
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(31 - i));
            #1;
            chk($sformatf("reset rd1 r%0d", i), ifa.ReadData1, 32'd0);
            chk($sformatf("reset rd2 r%0d", 31 - i), ifa.ReadData2, 32'd0);
            chk($sformatf("reset busy r%0d", i), 32'({ifa.Busy1, ifa.Busy2}), 32'd0);
        end
        chk("reset BusyCount", 32'(ifa.BusyCount), 32'd0);

        for (int i = 0; i < 20; i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            drive(vecs[i].wr, vecs[i].wreg, vecs[i].wdata, vecs[i].rs, vecs[i].rsreg,
                  vecs[i].r1, vecs[i].r2);
            e.idx = i; e.d1 = vecs[i].d1; e.b1 = vecs[i].b1;
            e.d2 = vecs[i].d2; e.b2 = vecs[i].b2; e.cnt = vecs[i].cnt;
            exp_q.push_back(e);
        end
        @(negedge clk);
        #1;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        // Async reset mid-cycle clears data, busy and count without a clock edge.
        @(posedge clk); #1 drive(1'b1, 5'd10, 32'hFFFF0000, 1'b1, 5'd10, 5'd10, 5'd11);
        @(posedge clk); #1 drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 5'd10, 5'd11);
        @(posedge clk); #1 idle(5'd10, 5'd11);
        @(negedge clk);
        chk("pre-reset rd1 r10", ifa.ReadData1, 32'hFFFF0000);
        chk("pre-reset busy r10", 32'(ifa.Busy1), 32'd1);
        chk("pre-reset BusyCount", 32'(ifa.BusyCount), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("mid-reset rd1 r10", ifa.ReadData1, 32'd0);
        chk("mid-reset busy r11", 32'(ifa.Busy2), 32'd0);
        chk("mid-reset BusyCount", 32'(ifa.BusyCount), 32'd0);
        drive(1'b1, 5'd10, 32'h00000123, 1'b1, 5'd10, 5'd10, 5'd11);
        #1;
        chk("reset blocks bypass", ifa.ReadData1, 32'd0);
        @(posedge clk); #1;
        chk("reset blocks write", ifa.ReadData1, 32'd0);
        chk("reset blocks reserve", 32'(ifa.BusyCount), 32'd0);
        reset = 1'b0;
        drive(1'b1, 5'd10, 32'h00000077, 1'b0, 5'd0, 5'd10, 5'd10);
        @(posedge clk); #1 idle(5'd10, 5'd10);
        #1;
        chk("post-reset write", ifa.ReadData1, 32'h00000077);
        chk("post-reset busy", 32'(ifa.Busy1), 32'd0);

        // No-bypass instance returns the old value during the write cycle.
        @(posedge clk); #1 drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5);
        #1;
        chk("nobyp same-cycle", ifb.ReadData1, 32'd0);
        chk("byp same-cycle", ifa.ReadData1, 32'hDEADBEEF);
        @(posedge clk); #1 idle(5'd5, 5'd5);
        #1;
        chk("nobyp next-cycle", ifb.ReadData1, 32'hDEADBEEF);

        // Register 0 as a normal register when the zero register is disabled.
        @(posedge clk); #1 drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
        #1;
        chk("zero0 bypass r0", ifc.ReadData1, 32'h12345678);
        chk("zero1 r0 write", ifa.ReadData1, 32'd0);
        @(posedge clk); #1 idle(5'd0, 5'd0);
        #1;
        chk("zero0 r0 stored", ifc.ReadData1, 32'h12345678);
        chk("zero0 r0 busy", 32'(ifc.Busy1), 32'd1);
        chk("zero0 BusyCount", 32'(ifc.BusyCount), 32'd1);
        chk("zero1 r0 busy", 32'(ifa.Busy1), 32'd0);
        chk("zero1 BusyCount", 32'(ifa.BusyCount), 32'd0);

        // Reserve every register to reach the maximum count.
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1 drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'd0, 5'd31);
        end
        @(posedge clk); #1 idle(5'd0, 5'd31);
        #1;
        chk("full BusyCount zero1", 32'(ifa.BusyCount), 32'd31);
        chk("full BusyCount nobyp", 32'(ifb.BusyCount), 32'd31);
        chk("full BusyCount zero0", 32'(ifc.BusyCount), 32'd32);
        chk("full busy r31", 32'(ifa.Busy2), 32'd1);
        chk("full zero1 r0 busy", 32'(ifa.Busy1), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised general-purpose register file with two combinational read ports, one synchronous write port, a hardwired zero register and optional write-to-read bypass. It carries a per-register busy scoreboard, so pipelined datapath control can stall on operands whose producer has issued but not yet written back. It replaces the fixed 32x32 file in the datapath. All state clears on reset, so there is no dependence on a preload file.

Parameters:
DATA_WIDTH, 32, width of each register and of all data ports
ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 always reads 0; writes and reserves to it are ignored
BYPASS, 1, 1 = a same-cycle write is forwarded to read data and masks busy

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
ReadRegister1  input  ADDR_WIDTH  read port 1 index
ReadRegister2  input  ADDR_WIDTH  read port 2 index
ReadData1  output  DATA_WIDTH  read port 1 data (combinational)
ReadData2  output  DATA_WIDTH  read port 2 data (combinational)
Busy1  output  1  read port 1 register has an outstanding producer
Busy2  output  1  read port 2 register has an outstanding producer
Write  input  1  write enable, sampled at posedge clk
WriteRegister  input  ADDR_WIDTH  write index
WriteData  input  DATA_WIDTH  write data
Reserve  input  1  mark ReserveRegister busy at posedge clk
ReserveRegister  input  ADDR_WIDTH  register to reserve
BusyCount  output  ADDR_WIDTH+1  number of registers currently busy (registered)

Behaviour:
- Reset (async, reset=1): all registers = 0; all busy bits = 0; BusyCount = 0. Reset takes effect immediately, mid-cycle. While reset is high, ReadData* = 0, Busy* = 0, and Write/Reserve are ignored.
- Write: at posedge clk with Write=1, registers[WriteRegister] <= WriteData and busy[WriteRegister] <= 0. Write latency is 1 cycle; the stored value is visible on the unbypassed path in the next cycle.
- Read data: ReadDataN = registers[ReadRegisterN], purely combinational, 0-cycle latency.
- BYPASS=1: if Write=1 and WriteRegister==ReadRegisterN (and not the zero register), then ReadDataN = WriteData and BusyN = 0 in the same cycle.
- BYPASS=0: reads return the old value until the next cycle.
- Busy: BusyN = busy[ReadRegisterN], after bypass masking.
- Reserve: at posedge with Reserve=1, busy[ReserveRegister] <= 1. Reserving an already-busy register is legal; it stays 1 and there is no nesting count.
- Write and Reserve to the same register in the same cycle: data is written, and reserve wins, so busy = 1 (a newer producer is in flight).
- Write and Reserve to different registers: both take effect independently.
- ZERO_REG=1: ReadDataN = 0 and BusyN = 0 whenever ReadRegisterN = 0. Write and Reserve to index 0 are dropped (no state change, no BusyCount change). Bypass never applies to index 0.
- ZERO_REG=0: register 0 behaves like any other register.
- BusyCount: registered population count of busy bits, updated at the same edge as the busy bits. Net change per cycle is -1, 0 or +1:
  - +1 when a not-busy register is reserved.
  - -1 when a busy register is written and not re-reserved.
  - 0 for a same-register write+reserve on a busy register.
  - Maximum is NUM_REGS (NUM_REGS-1 with ZERO_REG=1). No overflow is possible at width ADDR_WIDTH+1.
- Both read ports may address the same register; they return identical data and busy.
- Writing a register that is not busy is legal; busy stays 0.
- Deassertion of reset is assumed synchronous to clk by the surrounding reset logic. The first active edge after deassertion behaves normally.

Test Plan:
1. Reset then idle → every ReadRegister 0..31 reads 0x00000000; Busy1=Busy2=0; BusyCount=0.
2. Write=1, WriteRegister=5, WriteData=0xDEADBEEF; same cycle ReadRegister1=5 → ReadData1=0xDEADBEEF combinationally (BYPASS=1). Repeat with BYPASS=0 → old value 0 this cycle, 0xDEADBEEF next cycle.
3. Write 0x12345678 to reg 0 and Reserve reg 0 → ReadData1 (ReadRegister1=0) = 0, Busy1=0, BusyCount=0. Repeat with ZERO_REG=0 → reads 0x12345678 and BusyCount=1.
4. Reserve reg 7, then reg 9 on consecutive cycles → BusyCount=2, Busy1=1 for reg 7. Next cycle write reg 7 = 0xA5A5A5A5 → same cycle Busy1=0 with bypass; next cycle BusyCount=1.
5. Reg 3 busy; same cycle Write reg 3 = 0x1 and Reserve reg 3 → next cycle ReadData of reg 3 = 0x1, busy[3]=1, BusyCount unchanged.
6. Load reg 10 = 0xFFFF0000 and reserve regs 10 and 11, then assert reset between clock edges → ReadData (reg 10) = 0 and BusyCount=0 immediately without a clock edge. A write after deassertion works normally.
